// File: rtl/pla_vg2_vector_driver.sv
// rtl/pla_vg2_vector_driver.sv - command-to-vector driver for the vg2 PLA; optional z check under PLA_VG2_VECTOR_DRIVER_CHECK_EN
// One command at a time: encode into x00..x24, hold SETTLE cycles, capture z0..z7, return on handshake.
module pla_vg2_vector_driver #(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_src,
  input  logic             cmd_hi,
  input  logic             cmd_lo,
  input  logic [13:0]      cmd_field,
  output logic [24:0]      vec_x,
  input  logic [7:0]       pla_z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_z,
  output logic             rsp_err,
  output logic [CNT_W-1:0] txn_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t           r_state;
  logic [3:0]       r_settle;
  logic [24:0]      r_vec;
  logic             r_rsp_valid;
  logic [7:0]       r_rsp_z;
  logic             r_rsp_err;
  logic [CNT_W-1:0] r_txn_cnt;

  logic [24:0]      w_vec;
  logic             w_cmd_fire;
  logic             w_rsp_fire;
  logic             w_chk_err;

  assign cmd_ready  = (r_state == S_IDLE) & rst_n;
  assign w_cmd_fire = cmd_valid & cmd_ready;
  assign w_rsp_fire = (r_state == S_RESP) & rsp_ready;

  assign vec_x     = r_vec;
  assign rsp_valid = r_rsp_valid;
  assign rsp_z     = r_rsp_z;
  assign rsp_err   = r_rsp_err;
  assign txn_cnt   = r_txn_cnt;

  // Each source enables its own select term and steers hi/lo onto its private x lines.
  always_comb begin
    w_vec          = '0;
    w_vec[24:11]   = cmd_field;
    case (cmd_src)
      2'd0: begin
        w_vec[0] = 1'b1;
        w_vec[2] = 1'b1;
        w_vec[3] = cmd_hi;
        w_vec[8] = cmd_lo;
      end
      2'd1: begin
        w_vec[4]  = 1'b1;
        w_vec[7]  = cmd_hi;
        w_vec[10] = cmd_lo;
      end
      2'd2: begin
        w_vec[1] = 1'b1;
        w_vec[6] = cmd_hi;
        w_vec[9] = cmd_lo;
      end
      default: w_vec = '0;
    endcase
  end

`ifdef PLA_VG2_VECTOR_DRIVER_CHECK_EN
  logic       w_exp_hi;
  logic       w_exp_lo;
  logic [5:0] w_sel_bits;
  logic [7:0] w_exp_z;

  // The held vector still carries the command, so hi/lo are recovered from it rather than stored twice.
  assign w_exp_hi   = r_vec[3] | r_vec[7] | r_vec[6];
  assign w_exp_lo   = r_vec[8] | r_vec[10] | r_vec[9];
  assign w_sel_bits = {r_vec[19:16], r_vec[12:11]};
  assign w_exp_z    = {w_exp_lo & ~|w_sel_bits, w_exp_hi & &w_sel_bits, 4'b0000, w_exp_lo, w_exp_hi};
  assign w_chk_err  = |((pla_z ^ w_exp_z) & 8'hC3);
`else
  assign w_chk_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_settle    <= '0;
      r_vec       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_z     <= '0;
      r_rsp_err   <= 1'b0;
      r_txn_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            if (cmd_src == 2'd3) begin
              r_vec       <= '0;
              r_rsp_z     <= '0;
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_vec     <= w_vec;
              r_settle  <= 4'(SETTLE - 1);
              r_rsp_z   <= '0;
              r_rsp_err <= 1'b0;
              r_state   <= S_DRIVE;
            end
          end
        end
        S_DRIVE: begin
          if (r_settle == 4'd0) begin
            r_rsp_z     <= pla_z;
            r_rsp_err   <= w_chk_err;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_settle <= r_settle - 4'd1;
          end
        end
        S_RESP: begin
          if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
            r_vec       <= '0;
            r_state     <= S_IDLE;
            if (r_txn_cnt != '1) begin
              r_txn_cnt <= r_txn_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pla_vg2_vector_driver.sv
// tb/tb_pla_vg2_vector_driver.sv - randomized self-checking bench for pla_vg2_vector_driver
module tb_pla_vg2_vector_driver;

  localparam int SETTLE = 2;
  localparam int CNT_W  = 16;
`ifdef PLA_VG2_VECTOR_DRIVER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_src;
  logic             cmd_hi;
  logic             cmd_lo;
  logic [13:0]      cmd_field;
  logic [24:0]      vec_x;
  logic [7:0]       pla_z;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_z;
  logic             rsp_err;
  logic [CNT_W-1:0] txn_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  int sel_mask [3] = '{32'h5, 32'h10, 32'h2};
  int hi_pos   [3] = '{3, 7, 6};
  int lo_pos   [3] = '{8, 10, 9};

  always #5 clk = ~clk;

  pla_vg2_vector_driver #(.SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_hi(cmd_hi), .cmd_lo(cmd_lo), .cmd_field(cmd_field),
    .vec_x(vec_x), .pla_z(pla_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_err(rsp_err), .txn_cnt(txn_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] ref_encode(input logic [1:0] src, input logic hi, input logic lo,
                                             input logic [13:0] f);
    int v;
    if (src == 2'd3) return 25'd0;
    v = (int'(f) << 11) | sel_mask[src] | (int'(hi) << hi_pos[src]) | (int'(lo) << lo_pos[src]);
    return v[24:0];
  endfunction

  // Expected z0,z1,z6,z7 from command data; z2..z5 are left at zero.
  function automatic logic [7:0] ref_z(input logic hi, input logic lo, input logic [13:0] f);
    int m;
    m = int'(f) & 32'h1E3;
    return {lo && (m == 0), hi && (m == 32'h1E3), 4'b0000, lo, hi};
  endfunction

  function automatic logic ref_err(input logic hi, input logic lo, input logic [13:0] f,
                                   input logic [7:0] z);
    return ((z ^ ref_z(hi, lo, f)) & 8'hC3) != 8'h00;
  endfunction

  // zmode: 0 = model PLA, 1 = random every cycle, 2 = forced constant
  task automatic run_txn(input logic [1:0] src, input logic hi, input logic lo, input logic [13:0] f,
                         input int zmode, input logic [7:0] zforced, input int hold, input bit keep_valid);
    logic [24:0] ev;
    logic [7:0]  ez;
    logic [7:0]  zlast;
    logic        eerr;
    ev = ref_encode(src, hi, lo, f);
    check("idle_ready", cmd_ready, 1);
    check("idle_vec", vec_x, 0);
    cmd_src   = src;
    cmd_hi    = hi;
    cmd_lo    = lo;
    cmd_field = f;
    cmd_valid = 1'b1;
    pla_z     = (zmode == 0) ? ref_z(hi, lo, f) : (zmode == 2) ? zforced : 8'($urandom);
    zlast     = pla_z;
    @(posedge clk); #1;
    if (!keep_valid) cmd_valid = 1'b0;
    cmd_src   = 2'($urandom);
    cmd_hi    = 1'($urandom);
    cmd_lo    = 1'($urandom);
    cmd_field = 14'($urandom);
    check("accept_vec", vec_x, ev);
    if (src == 2'd3) begin
      ez   = 8'h00;
      eerr = 1'b1;
    end else begin
      for (int c = 1; c <= SETTLE; c++) begin
        check("drive_vec", vec_x, ev);
        check("drive_nvalid", rsp_valid, 0);
        check("drive_nready", cmd_ready, 0);
        if (zmode == 1) pla_z = 8'($urandom);
        zlast = pla_z;
        @(posedge clk); #1;
      end
      ez   = zlast;
      eerr = CHK ? ref_err(hi, lo, f, zlast) : 1'b0;
      if (zmode == 1) pla_z = 8'($urandom);
    end
    for (int h = 0; h <= hold; h++) begin
      check("rsp_valid", rsp_valid, 1);
      check("rsp_z", rsp_z, ez);
      check("rsp_err", rsp_err, eerr);
      check("rsp_vec", vec_x, ev);
      check("rsp_nready", cmd_ready, 0);
      check("rsp_cnt", txn_cnt, exp_cnt);
      if (h < hold) begin
        if (zmode == 1) pla_z = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    exp_cnt++;
    check("done_nvalid", rsp_valid, 0);
    check("done_vec", vec_x, 0);
    check("done_ready", cmd_ready, 1);
    check("done_cnt", txn_cnt, exp_cnt);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_src   = 2'd0;
    cmd_hi    = 1'b0;
    cmd_lo    = 1'b0;
    cmd_field = 14'd0;
    pla_z     = 8'hFF;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vec", vec_x, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_cnt", txn_cnt, 0);
    check("rst_err", rsp_err, 0);
    check("rst_ready", cmd_ready, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", cmd_ready, 1);
    @(posedge clk); #1;

    check("enc_a", ref_encode(2'd0, 1'b1, 1'b0, 14'h3FFF), 32'h1FFF80D);
    check("enc_b", ref_encode(2'd1, 1'b0, 1'b1, 14'h0000), 32'h0000410);
    run_txn(2'd0, 1'b1, 1'b0, 14'h3FFF, 1, 8'h00, 0, 1'b0);
    run_txn(2'd1, 1'b0, 1'b1, 14'h0000, 0, 8'h00, 0, 1'b0);
    check("model_b_z", ref_z(1'b0, 1'b1, 14'h0000), 32'h82);
    run_txn(2'd3, 1'b1, 1'b1, 14'h1234, 1, 8'h00, 0, 1'b0);
    run_txn(2'd0, 1'b1, 1'b1, 14'h2A5C, 1, 8'h00, 5, 1'b1);
    run_txn(2'd3, 1'b0, 1'b0, 14'h0000, 1, 8'h00, 5, 1'b1);

    cmd_src   = 2'd2;
    cmd_hi    = 1'b1;
    cmd_lo    = 1'b1;
    cmd_field = 14'h0F0F;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("prerst_vec", vec_x, ref_encode(2'd2, 1'b1, 1'b1, 14'h0F0F));
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_cnt = 0;
    check("midrst_vec", vec_x, 0);
    check("midrst_valid", rsp_valid, 0);
    check("midrst_cnt", txn_cnt, 0);
    check("midrst_ready", cmd_ready, 0);
    rst_n = 1'b1;
    for (int i = 0; i < SETTLE + 3; i++) begin
      @(posedge clk); #1;
      check("after_rst_nvalid", rsp_valid, 0);
      check("after_rst_vec", vec_x, 0);
    end

    run_txn(2'd2, 1'b1, 1'b0, 14'h3FFF, 2, 8'h01, 0, 1'b0);
    run_txn(2'd2, 1'b1, 1'b0, 14'h3FFF, 2, 8'h41, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      logic [1:0]  s;
      logic [13:0] f;
      s = 2'($urandom);
      f = 14'($urandom);
      if ($urandom_range(0, 3) == 0) f = ($urandom_range(0, 1) == 1) ? 14'h01E3 : 14'h0000;
      run_txn(s, 1'($urandom), 1'($urandom), f, int'($urandom_range(0, 2)), 8'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
